// File: rtl/alu_duty_feeder.sv
// Duty-value feeder for the PWM LED driver: buffers ALU results in a small FIFO and
// walks the PWM duty toward each entry one step per PWM period, then dwells.
module alu_duty_feeder #(
  parameter int DATA_W        = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int PERIOD_CYCLES = 16,
  parameter int DWELL_PERIODS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             alu_result,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  output logic [DATA_W-1:0]             RegALU,
  output logic                          period_tick,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int DWW = $clog2(DWELL_PERIODS + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RAMP,
    DWELL
  } state_t;

  logic [PW-1:0]     per_cnt_reg;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  state_t            state_reg, state_next;
  logic [DATA_W-1:0] target_reg, target_next;
  logic [DATA_W-1:0] duty_reg, duty_next;
  logic [DWW-1:0]    dwell_reg, dwell_next;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] step_val;
  logic              full;
  logic              push;
  logic              pop;

  assign period_tick = (per_cnt_reg == PW'(PERIOD_CYCLES - 1));
  assign full        = (count_reg == CW'(FIFO_DEPTH));
  assign alu_ready   = !rst && !full;
  assign push        = alu_valid && alu_ready;
  assign head        = fifo_mem[rd_ptr_reg];
  assign step_val    = (target_reg > duty_reg) ? duty_reg + DATA_W'(1) : duty_reg - DATA_W'(1);

  assign RegALU      = duty_reg;
  assign busy        = (state_reg != IDLE);
  assign fifo_count  = count_reg;

  // Free-running period counter; must stay phase-locked to the PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt_reg <= '0;
    end else if (period_tick) begin
      per_cnt_reg <= '0;
    end else begin
      per_cnt_reg <= per_cnt_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= alu_result;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      target_reg <= '0;
      duty_reg   <= '0;
      dwell_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      duty_reg   <= duty_next;
      dwell_reg  <= dwell_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    duty_next   = duty_reg;
    dwell_next  = dwell_reg;
    pop         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        pop         = 1'b1;
        target_next = head;
        dwell_next  = '0;
        state_next  = (head != duty_reg) ? RAMP : DWELL;
      end
      RAMP: begin
        // Duty only moves on the last cycle of a period, so the PWM never sees a mid-period change.
        if (period_tick) begin
          duty_next = step_val;
          if (step_val == target_reg) begin
            state_next = DWELL;
            dwell_next = '0;
          end
        end
      end
      DWELL: begin
        if (period_tick) begin
          dwell_next = dwell_reg + DWW'(1);
          if (dwell_reg + DWW'(1) == DWW'(DWELL_PERIODS)) begin
            state_next = (count_reg != '0) ? LOAD : IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_duty_feeder.sv
// Bench for alu_duty_feeder: directed scenarios plus random pushes/resets, with a
// scoreboard of expected RegALU steps checked by an independent monitor.
module tb_alu_duty_feeder;

  localparam int DW  = 4;
  localparam int FD  = 4;
  localparam int PC  = 4;
  localparam int DWL = 2;
  localparam int CW  = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] alu_result = '0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [DW-1:0] RegALU;
  logic          period_tick;
  logic          busy;
  logic [CW-1:0] fifo_count;

  alu_duty_feeder #(
    .DATA_W(DW),
    .FIFO_DEPTH(FD),
    .PERIOD_CYCLES(PC),
    .DWELL_PERIODS(DWL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alu_result(alu_result),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .RegALU(RegALU),
    .period_tick(period_tick),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int model_val = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference model: the duty walks one unit at a time from the previous target to the new one.
  task automatic model_push(input int v);
    while (model_val != v) begin
      model_val = (v > model_val) ? model_val + 1 : model_val - 1;
      exp_q.push_back(model_val);
    end
  endtask

  // Monitor: every RegALU change must follow a period tick and match the next queued step.
  logic rst_prev  = 1'b0;
  logic tick_prev = 1'b0;
  int   prev_reg  = 0;
  int   exp_c     = 0;
  bit   ph_ok     = 1'b0;
  always @(negedge clk) begin
    int e;
    if (rst_prev) begin
      exp_c = 0;
      ph_ok = 1'b1;
    end else begin
      exp_c = (exp_c + 1) % PC;
    end
    if (ph_ok) check("period_tick_phase", period_tick, int'(exp_c == PC - 1));
    if (int'(RegALU) != prev_reg) begin
      if (rst_prev) begin
        check("reset_regalu", RegALU, 0);
      end else begin
        check("change_after_tick", tick_prev, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: RegALU=%0d, required %0d (no step queued)", RegALU, prev_reg);
        end else begin
          e = exp_q.pop_front();
          check("regalu_step", RegALU, e);
        end
      end
      prev_reg = RegALU;
    end
    if (rst) exp_q.delete();
    rst_prev  = rst;
    tick_prev = period_tick;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after a posedge; returns at #1 after the next posedge.
  task automatic drive_cycle(input bit vld, input int v, output bit acc);
    alu_valid  = vld;
    alu_result = DW'(v);
    @(negedge clk);
    acc = vld && alu_ready;
    if (acc) model_push(v);
    if (vld) $display("push %0d %s (fifo_count=%0d)", v, acc ? "accepted" : "refused", fifo_count);
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_val = 0;
    repeat (n) sync();
    rst = 1'b0;
    $display("reset %0d cycles", n);
  endtask

  task automatic wait_change(output int cyc);
    int start;
    start = RegALU;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (int'(RegALU) == start && cyc < 300);
    if (int'(RegALU) == start) check("wait_change_timeout", int'(int'(RegALU) != start), 1);
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((busy || fifo_count != 0) && cyc < bound);
    if (busy || fifo_count != 0) check("wait_idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int  c;
    bit  acc;
    bit  seen;
    int  burst[5];

    // 1: reset behaviour and tick phase after release
    repeat (3) begin
      @(negedge clk);
      check("ready_in_reset", alu_ready, 0);
    end
    sync();
    check("reset_regalu_val", RegALU, 0);
    check("reset_fifo_count", fifo_count, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) check("ready_after_reset", alu_ready, 1);
      check("first_tick_position", period_tick, int'(i == 4));
    end

    // 2: up-ramp to 3, dwell 2 periods, then idle
    sync();
    drive_cycle(1'b1, 3, acc);
    wait_change(c);
    check("up_first_step", RegALU, 1);
    wait_change(c);
    check("up_step_spacing", c, PC);
    wait_change(c);
    check("up_step_spacing", c, PC);
    check("up_reach", RegALU, 3);
    repeat (DWL * PC - 1) @(negedge clk);
    check("dwell_busy_before_end", busy, 1);
    @(negedge clk);
    check("dwell_busy_after_end", busy, 0);
    check("hold_value", RegALU, 3);

    // 3: back-to-back 15 then 12
    sync();
    drive_cycle(1'b1, 15, acc);
    drive_cycle(1'b1, 12, acc);
    for (int i = 0; i < 12; i++) wait_change(c);
    check("reach_15", RegALU, 15);
    wait_change(c);
    check("dwell_then_load_gap", c, (DWL + 1) * PC);
    check("down_first", RegALU, 14);
    wait_change(c);
    check("down_spacing", c, PC);
    wait_change(c);
    check("down_spacing", c, PC);
    check("reach_12", RegALU, 12);

    // 4: five pushes during DWELL; the fifth is refused
    burst[0] = 10; burst[1] = 11; burst[2] = 9; burst[3] = 8; burst[4] = 1;
    sync();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, burst[i], acc);
      check("burst_accept", acc, int'(i < 4));
    end
    check("burst_fifo_count", fifo_count, 4);
    check("burst_full_ready", alu_ready, 0);
    wait_idle(1000, c);
    check("burst_drained", exp_q.size(), 0);
    check("burst_final", RegALU, model_val);

    // 5: equal target causes a dwell with no RegALU change
    sync();
    drive_cycle(1'b1, 7, acc);
    wait_idle(500, c);
    check("reach_7", RegALU, 7);
    sync();
    drive_cycle(1'b1, 7, acc);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    check("equal_busy_seen", seen, 1);
    wait_idle(100, c);
    check("equal_dwell_len", int'(c >= (DWL - 1) * PC + 1 && c <= DWL * PC + 2), 1);
    check("equal_hold", RegALU, 7);

    // 6: reset mid-ramp with entries queued
    sync();
    do_reset(1);
    drive_cycle(1'b1, 9, acc);
    drive_cycle(1'b1, 3, acc);
    drive_cycle(1'b1, 6, acc);
    for (int i = 0; i < 4; i++) wait_change(c);
    check("mid_ramp_val", RegALU, 4);
    sync();
    check("mid_ramp_queued", fifo_count, 2);
    rst = 1'b1;
    model_val = 0;
    sync();
    check("midreset_regalu", RegALU, 0);
    check("midreset_fifo", fifo_count, 0);
    check("midreset_busy", busy, 0);
    check("midreset_ready", alu_ready, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset_regalu", RegALU, 0);
    check("post_reset_busy", busy, 0);

    // Random traffic with occasional resets
    sync();
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_reset(1 + $urandom_range(0, 2));
        check("rand_reset_regalu", RegALU, 0);
        check("rand_reset_fifo", fifo_count, 0);
      end else if (r < 12) begin
        drive_cycle(1'b1, $urandom_range(0, 15), acc);
      end else begin
        repeat ($urandom_range(1, 30)) sync();
      end
    end
    wait_idle(3000, c);
    check("rand_drained", exp_q.size(), 0);
    check("rand_final", RegALU, model_val);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
